time_keeper: RTL

//  Consumes the 1 Hz single-cycle tick and the 2 Hz blink level produced by the

---
 rtl/clock_pkg.sv | 33 +++
 rtl/bcd_mod_counter.sv | 48 ++++
 rtl/time_keeper.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
//  Shared types and constants for the time-keeping slice.
//  - mode_t      : user-interface mode (RUN / SET_H / SET_M / SET_S)
//  - bcd2_t      : two-digit packed BCD value {tens, ones}
//  - SEC_MAX     : last legal seconds value before wrap (BCD 59)
//  - MIN_MAX     : last legal minutes value before wrap (BCD 59)
//  - to_bcd()    : converts a small binary constant (0..99) to packed BCD,
//                  used to turn the decimal HOUR_MAX parameter into the
//                  value the hour counter compares against.
// -----------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } mode_t;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t SEC_MAX = 8'h59;
  localparam bcd2_t MIN_MAX = 8'h59;

  function automatic bcd2_t to_bcd(input int unsigned v);
    bcd2_t r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter
//  Two-digit BCD counter that wraps to 00 after MAX_BCD.
//  Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (value -> 00)
//   inc    in   advance by one (ones 9->0 carries into tens)
//   clr    in   force value to 00; has priority over inc
//   value  out  registered {tens, ones}
//   wrap   out  combinational: inc && value == MAX_BCD (this inc wraps to 00)
//  The wrap compare uses the full 8-bit BCD value, so the counter can never
//  reach an illegal code as long as MAX_BCD itself is legal BCD.
// -----------------------------------------------------------------------------
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter bcd2_t MAX_BCD = 8'h59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       wrap
);

  bcd2_t value_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else if (clr) begin
      value_q <= '0;
    end else if (inc) begin
      if (value_q == MAX_BCD) begin
        value_q <= '0;
      end else if (value_q[3:0] == 4'd9) begin
        value_q <= {value_q[7:4] + 4'd1, 4'd0};
      end else begin
        value_q <= {value_q[7:4], value_q[3:0] + 4'd1};
      end
    end
  end

  assign value = value_q;
  assign wrap  = inc && (value_q == MAX_BCD);

endmodule

// File: rtl/time_keeper.sv
// -----------------------------------------------------------------------------
// time_keeper
//  Keeps HH:MM:SS time in BCD from a 1 Hz tick and lets the user set it with
//  two debounced buttons. Sits between the clock divider and the 7-segment
//  display driver.
//  Parameters:
//   HOUR_MAX     last hour before wrap (23 = 24 h clock, 11 = 0..11 mode)
//  Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   tick_1hz     in   one-cycle pulse per second
//   blink        in   2 Hz level, 1 = blank the field being set
//   btn_mode     in   one-cycle pulse: RUN -> SET_H -> SET_M -> SET_S -> RUN
//   btn_inc      in   one-cycle pulse: edit the selected field
//   hour_bcd     out  {tens,ones} hours
//   min_bcd      out  {tens,ones} minutes
//   sec_bcd      out  {tens,ones} seconds
//   digit_blank  out  [5:4]=hour, [3:2]=min, [1:0]=sec; 1 = digit off
//   mode         out  current mode (mode_t encoding)
//   day_pulse    out  one-cycle pulse in the cycle the time first reads
//                     00:00:00 after HOUR_MAX:59:59 while running
//  Every output is a register, so any input event shows up one clock later.
// -----------------------------------------------------------------------------
module time_keeper
  import clock_pkg::*;
#(
  parameter int HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       blink,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [5:0] digit_blank,
  output logic [1:0] mode,
  output logic       day_pulse
);

  localparam bcd2_t HOUR_MAX_BCD = to_bcd(HOUR_MAX);

  mode_t      mode_q;
  mode_t      mode_next;
  logic [5:0] blank_q;
  logic [5:0] blank_next;
  logic       day_q;

  logic       running;
  logic       edit;
  logic       sec_inc;
  logic       sec_clr;
  logic       min_inc;
  logic       hour_inc;
  logic       sec_wrap;
  logic       min_wrap;
  logic       hour_wrap;
  bcd2_t      sec_val;
  bcd2_t      min_val;
  bcd2_t      hour_val;

  // A mode press takes priority over an edit in the same cycle, so btn_inc is
  // only honoured when btn_mode is quiet. The tick is only honoured in RUN,
  // which means a tick coincident with leaving RUN still lands, while a tick
  // coincident with leaving SET_S is dropped.
  assign running  = (mode_q == RUN);
  assign edit     = btn_inc && !btn_mode;

  // Carries ripple only while running; in the SET modes each field is edited
  // in isolation so a minute wrap never touches the hour.
  assign sec_inc  = running && tick_1hz;
  assign sec_clr  = (mode_q == SET_S) && edit;
  assign min_inc  = running ? sec_wrap : ((mode_q == SET_M) && edit);
  assign hour_inc = running ? min_wrap : ((mode_q == SET_H) && edit);

  bcd_mod_counter #(.MAX_BCD(SEC_MAX)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_inc),
    .clr   (sec_clr),
    .value (sec_val),
    .wrap  (sec_wrap)
  );

  bcd_mod_counter #(.MAX_BCD(MIN_MAX)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .clr   (1'b0),
    .value (min_val),
    .wrap  (min_wrap)
  );

  bcd_mod_counter #(.MAX_BCD(HOUR_MAX_BCD)) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hour_inc),
    .clr   (1'b0),
    .value (hour_val),
    .wrap  (hour_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= RUN;
      blank_q <= '0;
      day_q   <= 1'b0;
    end else begin
      mode_q  <= mode_next;
      blank_q <= blank_next;
      day_q   <= running && hour_wrap;
    end
  end

  // Blanking is derived from the mode being entered rather than the current
  // one, so the blank pattern changes in the same cycle the mode output does.
  always_comb begin
    mode_next  = mode_q;
    blank_next = '0;

    if (btn_mode) begin
      unique case (mode_q)
        RUN:     mode_next = SET_H;
        SET_H:   mode_next = SET_M;
        SET_M:   mode_next = SET_S;
        SET_S:   mode_next = RUN;
        default: mode_next = RUN;
      endcase
    end

    unique case (mode_next)
      SET_H:   blank_next = {blink, blink, 4'b0000};
      SET_M:   blank_next = {2'b00, blink, blink, 2'b00};
      SET_S:   blank_next = {4'b0000, blink, blink};
      default: blank_next = '0;
    endcase
  end

  assign hour_bcd    = hour_val;
  assign min_bcd     = min_val;
  assign sec_bcd     = sec_val;
  assign digit_blank = blank_q;
  assign mode        = mode_q;
  assign day_pulse   = day_q;

endmodule
